// File: rtl/keypoint_write_arbiter.sv
// rtl/keypoint_write_arbiter.sv - merges two keypoint layer streams into one SRAM write port
// Two small per-layer FIFOs feed a round-robin grant that issues at most one SRAM write per cycle.
module keypoint_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              src_done_i,
  input  logic              kp0_we_i,
  input  logic [18:0]       kp0_din_i,
  input  logic              kp1_we_i,
  input  logic [18:0]       kp1_din_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [19:0]       mem_din_o,
  output logic [ADDR_W:0]   kp_count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q;
  logic [PW-1:0]     wp0_q, rp0_q, wp1_q, rp1_q;
  logic [18:0]       fifo0_q [FIFO_DEPTH];
  logic [18:0]       fifo1_q [FIFO_DEPTH];
  logic              prefer_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [19:0]       mem_din_q;
  logic [ADDR_W:0]   kp_count_q;
  logic              busy_q, done_q, overflow_q;

  logic empty0, empty1, full0, full1;
  logic push0, push1, drop0, drop1;
  logic gnt_v, gnt_l, sram_full;
  logic [18:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty0 = (wp0_q == rp0_q);
  assign empty1 = (wp1_q == rp1_q);
  assign full0  = (wp0_q[IW-1:0] == rp0_q[IW-1:0]) && (wp0_q[IW] != rp0_q[IW]);
  assign full1  = (wp1_q[IW-1:0] == rp1_q[IW-1:0]) && (wp1_q[IW] != rp1_q[IW]);

  assign push0 = (state_q == RUN) && kp0_we_i && !full0;
  assign push1 = (state_q == RUN) && kp1_we_i && !full1;
  assign drop0 = (state_q == RUN) && kp0_we_i && full0;
  assign drop1 = (state_q == RUN) && kp1_we_i && full1;

  // prefer_q names the layer that wins the next tie; it flips away from each granted layer.
  assign gnt_v     = ((state_q == RUN) || (state_q == DRAIN)) && !(empty0 && empty1);
  assign gnt_l     = (!empty0 && !empty1) ? prefer_q : empty0;
  assign head      = gnt_l ? fifo1_q[rp1_q[IW-1:0]] : fifo0_q[rp0_q[IW-1:0]];
  assign sram_full = kp_count_q[ADDR_W];

  always_ff @(posedge clk_i) begin
    if (push0) fifo0_q[wp0_q[IW-1:0]] <= kp0_din_i;
    if (push1) fifo1_q[wp1_q[IW-1:0]] <= kp1_din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wp0_q      <= '0;
      rp0_q      <= '0;
      wp1_q      <= '0;
      rp1_q      <= '0;
      prefer_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      kp_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            wp0_q      <= '0;
            rp0_q      <= '0;
            wp1_q      <= '0;
            rp1_q      <= '0;
            prefer_q   <= 1'b0;
            mem_addr_q <= '0;
            kp_count_q <= '0;
            overflow_q <= 1'b0;
          end
        end
        RUN: begin
          if (src_done_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!gnt_v) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      if (push0) wp0_q <= wp0_q + PTR_ONE;
      if (push1) wp1_q <= wp1_q + PTR_ONE;
      if (drop0 || drop1) overflow_q <= 1'b1;

      // Pops continue once the SRAM is full so the drain still terminates; those entries are lost.
      if (gnt_v) begin
        prefer_q <= !gnt_l;
        if (gnt_l) rp1_q <= rp1_q + PTR_ONE;
        else       rp0_q <= rp0_q + PTR_ONE;
        if (sram_full) begin
          overflow_q <= 1'b1;
        end else begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= kp_count_q[ADDR_W-1:0];
          mem_din_q  <= {gnt_l, head};
          kp_count_q <= kp_count_q + CNT_ONE;
        end
      end
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;
  assign kp_count_o = kp_count_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/keypoint_write_arbiter.md
KEYPOINT_WRITE_ARBITER -- requirements
Module: keypoint_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, per-layer keypoint buffer depth; SHALL be a power of 2 and at least 2.
REQ-002 Parameter ADDR_W, default 12, merged keypoint SRAM address width (4K entries).
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that begins a frame.
REQ-006 src_done  input  1  one-cycle pulse from the detect/filter stage marking the end of the frame.
REQ-007 kp0_we  input  1  layer-0 keypoint valid strobe.
REQ-008 kp0_din  input  19  layer-0 keypoint as {row[8:0], col[9:0]}.
REQ-009 kp1_we  input  1  layer-1 keypoint valid strobe.
REQ-010 kp1_din  input  19  layer-1 keypoint as {row[8:0], col[9:0]}.
REQ-011 mem_we  output  1  merged keypoint SRAM write enable; registered.
REQ-012 mem_addr  output  ADDR_W  merged keypoint SRAM write address; registered.
REQ-013 mem_din  output  20  write data {layer, row[8:0], col[9:0]}; registered.
REQ-014 kp_count  output  ADDR_W+1  number of keypoints written in this frame.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 done  output  1  one-cycle pulse when the frame is fully flushed to the SRAM.
REQ-017 overflow  output  1  sticky flag: at least one keypoint was lost in this frame.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE: start=1 SHALL move to RUN and, on that edge, clear mem_addr, kp_count, overflow, both FIFOs and the round-robin pointer.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 RUN: src_done=1 SHALL move to DRAIN; src_done SHALL be ignored in all other states.
REQ-022 DRAIN: the FSM SHALL move to DONE once both FIFOs are empty and no pop is issued in that cycle.
REQ-023 DONE: the FSM SHALL hold for exactly one cycle with done=1, then return to IDLE.
REQ-024 Push: in RUN, kpN_we=1 SHALL push kpN_din into FIFO N. In IDLE, DRAIN and DONE, kpN_we SHALL be ignored and SHALL NOT set overflow.
REQ-025 FIFO full is evaluated before any same-cycle pop. A push to a full FIFO SHALL be discarded and SHALL set overflow.
REQ-026 Simultaneous pushes to both FIFOs in the same cycle SHALL both be accepted, provided neither FIFO is full.
REQ-027 Pop: at most one pop SHALL occur per cycle, in RUN or DRAIN only.
REQ-028 If exactly one FIFO is non-empty, that FIFO SHALL be granted.
REQ-029 If both FIFOs are non-empty, the layer not granted last SHALL be granted. The pointer SHALL update only on a grant; after reset or start, layer 0 wins the first tie.
REQ-030 A pop at edge k SHALL produce mem_we=1 for one cycle after edge k, with mem_din={granted layer, entry} and mem_addr = current write pointer.
REQ-031 The write pointer and kp_count SHALL increment by 1 after each write.
REQ-032 Minimum latency from kpN_we sampled to mem_we high SHALL be 2 cycles. FIFO ordering per layer SHALL be preserved.
REQ-033 SRAM full: when kp_count = 2^ADDR_W, subsequent pops SHALL still occur but SHALL NOT assert mem_we. Each such pop SHALL set overflow, so the drain always terminates.
REQ-034 mem_addr SHALL never wrap.
REQ-035 mem_we SHALL be 0 in IDLE and DONE, except for the final write issued by the last DRAIN pop.

Reset
REQ-036 When rst_n=0, state SHALL go to IDLE, and mem_we, mem_addr, mem_din, kp_count, busy, done, overflow, both FIFOs and the RR pointer SHALL all be 0, independent of clk.
REQ-037 Reset mid-frame SHALL discard all buffered keypoints without emitting any write.

Verification
REQ-038 start; kp0_we with din=0x00005 at cycle 3; src_done at cycle 6 -> mem_we at cycle 5 with addr 0, din=0x00005; done pulses once; kp_count=1.
REQ-039 kp0_we and kp1_we every cycle for 6 cycles -> mem_din layer bit alternates 0,1,0,1 starting with 0; addresses consecutive; overflow=0.
REQ-040 kp0_we for 6 consecutive cycles while kp1 traffic stalls grants (FIFO_DEPTH=4) -> discarded pushes set overflow=1; surviving layer-0 entries are written in order.
REQ-041 ADDR_W=3; 10 keypoints offered -> exactly 8 writes at addr 0..7; kp_count=8; overflow=1; done still asserted after src_done.
REQ-042 rst_n asserted low mid-DRAIN with 3 entries buffered -> outputs 0 immediately; no further mem_we; a following start runs a clean frame from addr 0.
REQ-043 start pulsed during RUN, and src_done pulsed during IDLE -> both ignored; state and counters unchanged.
